// File: rtl/kfmmc_write_sequencer.sv
// Block-write sequencer feeding KFMMC_DRIVE: address, command, then one pattern byte per drive request.
// Optional `KFMMC_WRITE_RETRY_EN: one retry per block on a drive error before failing.
module kfmmc_write_sequencer #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter logic [7:0]  WRITE_CMD   = 8'h81
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_block,
  input  logic [7:0]  block_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  data_bus,
  output logic        write_block_address_1,
  output logic        write_block_address_2,
  output logic        write_block_address_3,
  output logic        write_block_address_4,
  output logic        write_command,
  output logic        write_data,
  input  logic        drive_busy,
  input  logic        write_byte_interrupt,
  input  logic        write_completion_interrupt,
  input  logic        write_interface_error
);

  localparam int unsigned IDX_W = $clog2(BLOCK_BYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_READY,
    S_ADDR_1,
    S_ADDR_2,
    S_ADDR_3,
    S_ADDR_4,
    S_CMD,
    S_WAIT_REQ,
    S_PUT_DATA,
    S_NEXT_BLOCK,
    S_FAIL,
    S_FINISH
  } state_t;

  state_t             state, next_state;
  logic [31:0]        cur_block;
  logic [7:0]         remaining;
  logic [IDX_W-1:0]   idx;
  logic               idx_full;
  logic               err_hit;
  state_t             err_target;

  logic [7:0]         nx_bus;
  logic [3:0]         nx_addr;
  logic               nx_cmd;
  logic               nx_wd;
  logic [3:0]         addr_stb;

`ifdef KFMMC_WRITE_RETRY_EN
  logic               retried;
`endif

  assign idx_full = (idx == IDX_W'(BLOCK_BYTES));
  assign err_hit  = write_interface_error &&
                    (state inside {S_WAIT_READY, S_ADDR_1, S_ADDR_2, S_ADDR_3,
                                   S_ADDR_4, S_CMD, S_WAIT_REQ, S_PUT_DATA});

`ifdef KFMMC_WRITE_RETRY_EN
  assign err_target = retried ? S_FAIL : S_WAIT_READY;
`else
  assign err_target = S_FAIL;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = (block_count == 8'd0) ? S_FINISH : S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (err_hit)          next_state = err_target;
        else if (!drive_busy) next_state = S_ADDR_1;
      end
      S_ADDR_1: next_state = err_hit ? err_target : S_ADDR_2;
      S_ADDR_2: next_state = err_hit ? err_target : S_ADDR_3;
      S_ADDR_3: next_state = err_hit ? err_target : S_ADDR_4;
      S_ADDR_4: next_state = err_hit ? err_target : S_CMD;
      S_CMD:    next_state = err_hit ? err_target : S_WAIT_REQ;
      S_WAIT_REQ: begin
        // error outranks a coincident completion; late byte requests fall through
        if (err_hit)                         next_state = err_target;
        else if (write_completion_interrupt) next_state = idx_full ? S_NEXT_BLOCK : S_FAIL;
        else if (write_byte_interrupt && !idx_full) next_state = S_PUT_DATA;
      end
      S_PUT_DATA:   next_state = err_hit ? err_target : S_WAIT_REQ;
      S_NEXT_BLOCK: next_state = (remaining == 8'd1) ? S_FINISH : S_WAIT_READY;
      S_FAIL:       next_state = S_FINISH;
      S_FINISH:     next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from next_state and registered so they line up with the state they belong to.
  always_comb begin
    nx_bus  = '0;
    nx_addr = '0;
    nx_cmd  = 1'b0;
    nx_wd   = 1'b0;
    case (next_state)
      S_ADDR_1: begin nx_addr[0] = 1'b1; nx_bus = cur_block[7:0];   end
      S_ADDR_2: begin nx_addr[1] = 1'b1; nx_bus = cur_block[15:8];  end
      S_ADDR_3: begin nx_addr[2] = 1'b1; nx_bus = cur_block[23:16]; end
      S_ADDR_4: begin nx_addr[3] = 1'b1; nx_bus = cur_block[31:24]; end
      S_CMD:    begin nx_cmd = 1'b1;     nx_bus = WRITE_CMD;        end
      S_PUT_DATA: begin
        nx_wd  = 1'b1;
        nx_bus = 8'(idx) + cur_block[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_bus      <= '0;
      addr_stb      <= '0;
      write_command <= 1'b0;
      write_data    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      data_bus      <= nx_bus;
      addr_stb      <= nx_addr;
      write_command <= nx_cmd;
      write_data    <= nx_wd;
      busy          <= (next_state != S_IDLE);
      done          <= (next_state == S_FINISH);
    end
  end

  assign write_block_address_1 = addr_stb[0];
  assign write_block_address_2 = addr_stb[1];
  assign write_block_address_3 = addr_stb[2];
  assign write_block_address_4 = addr_stb[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_block <= '0;
      remaining <= '0;
      idx       <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_block <= start_block;
            remaining <= block_count;
            error     <= 1'b0;
          end
        end
        S_CMD:      idx <= '0;
        S_PUT_DATA: idx <= idx + IDX_W'(1);
        S_NEXT_BLOCK: begin
          cur_block <= cur_block + 32'd1;
          remaining <= remaining - 8'd1;
        end
        S_FAIL:  error <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef KFMMC_WRITE_RETRY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retried <= 1'b0;
    end else if ((state == S_IDLE && start) || state == S_NEXT_BLOCK) begin
      retried <= 1'b0;
    end else if (err_hit) begin
      retried <= 1'b1;
    end
  end
`endif

endmodule
